// File: rtl/sig_z_pack_defines_pkg.sv
// Shared constants and FSM encoding for the ML-DSA signature z BitPack buffer.
package sig_z_pack_defines_pkg;

    localparam int COEFF_W         = 20;
    localparam int COEFFS_PER_BEAT = 4;
    localparam int NUM_POLY        = 7;
    localparam int N               = 256;
    localparam int WORD_W          = 32;

    localparam int BEAT_W      = COEFF_W * COEFFS_PER_BEAT;
    localparam int BUF_W       = 128;
    localparam int FILL_W      = 8;
    localparam int BEAT_CNT_W  = 9;
    localparam int ADDR_W      = 11;
    localparam int FILL_IN_MAX = BUF_W - BEAT_W;

    localparam int TOTAL_BEATS = NUM_POLY * N / COEFFS_PER_BEAT;
    localparam int TOTAL_WORDS = NUM_POLY * N * COEFF_W / WORD_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/sig_z_pack_buffer.sv
// Packs 4x20-bit z coefficients per beat into a little-endian 32-bit word stream.
// Define SIG_Z_PACK_PROTO_CHK_EN to build the sticky protocol-error checker.
module sig_z_pack_buffer
    import sig_z_pack_defines_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              zeroize,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BEAT_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_e                state_q, state_d;
    logic [BUF_W-1:0]      pbuf_q, pbuf_d, pbuf_pop;
    logic [FILL_W-1:0]     fill_q, fill_d, fill_pop;
    logic [BEAT_CNT_W-1:0] beat_q, beat_d;
    logic [ADDR_W-1:0]     word_q, word_d;
    logic                  in_fire, out_fire, active;

    assign active    = (state_q == RUN) || (state_q == DRAIN);
    assign out_valid = active && (fill_q >= FILL_W'(WORD_W));
    // Registered-only ready: room for a full beat without counting a same-cycle pop.
    assign in_ready  = (state_q == RUN) && (fill_q <= FILL_W'(FILL_IN_MAX));
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_data  = pbuf_q[WORD_W-1:0];
    assign out_addr  = word_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

    always_comb begin
        pbuf_pop = out_fire ? (pbuf_q >> WORD_W) : pbuf_q;
        fill_pop = out_fire ? (fill_q - FILL_W'(WORD_W)) : fill_q;
        pbuf_d   = pbuf_pop;
        fill_d   = fill_pop;
        beat_d   = beat_q;
        word_d   = out_fire ? (word_q + ADDR_W'(1)) : word_q;
        state_d  = state_q;

        if (in_fire) begin
            pbuf_d = pbuf_pop | (BUF_W'(in_data) << fill_pop);
            fill_d = fill_pop + FILL_W'(BEAT_W);
            beat_d = beat_q + BEAT_CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (in_fire && (beat_q == BEAT_CNT_W'(TOTAL_BEATS - 1)))
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (fill_d == '0) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                beat_d  = '0;
                word_d  = '0;
            end
            default: state_d = IDLE;
        endcase

        if (zeroize) begin
            state_d = IDLE;
            pbuf_d  = '0;
            fill_d  = '0;
            beat_d  = '0;
            word_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pbuf_q  <= '0;
            fill_q  <= '0;
            beat_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            pbuf_q  <= pbuf_d;
            fill_q  <= fill_d;
            beat_q  <= beat_d;
            word_q  <= word_d;
        end
    end

`ifdef SIG_Z_PACK_PROTO_CHK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q
              | (start && busy)
              | (in_valid && (state_q != RUN))
              | (out_fire && (word_q >= ADDR_W'(TOTAL_WORDS)));
        if (zeroize) err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_q <= 1'b0;
        else          err_q <= err_d;
    end

    assign error = err_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_sig_z_pack_buffer.sv
// Self-checking bench for sig_z_pack_buffer: vector table plus scoreboarded full runs.
`timescale 1ns/1ps
module tb_sig_z_pack_buffer;
    import sig_z_pack_defines_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n, zeroize, start, in_valid, out_ready;
    logic [79:0] in_data;
    logic        in_ready, out_valid, busy, done, error;
    logic [31:0] out_data;
    logic [10:0] out_addr;

    always #5 clk = ~clk;

    sig_z_pack_buffer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .zeroize   (zeroize),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    typedef struct {
        logic [10:0] addr;
        logic [31:0] data;
    } sb_t;

    typedef struct {
        logic [79:0]  beat;
        logic [159:0] words;
    } vec_t;

    sb_t         sb[$];
    logic [31:0] cap[$];
    logic [19:0] coef [0:1791];
    vec_t        tbl [6];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int src_idx, src_n, mfill, nwords, n_done, last_fire, done_cyc;
    int stall_lo = -1;
    int stall_hi = -1;
    bit in_run, saw_block;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Bit p of the stream is bit p%20 of coefficient p/20.
    function automatic logic [31:0] exp_word(input int a);
        logic [31:0] w;
        int p;
        for (int j = 0; j < 32; j++) begin
            p = 32 * a + j;
            w[j] = coef[p / 20][p % 20];
        end
        return w;
    endfunction

    task automatic model_reset();
        sb.delete();
        cap.delete();
        src_idx   = 0;
        mfill     = 0;
        nwords    = 0;
        n_done    = 0;
        last_fire = -100;
        done_cyc  = -100;
        in_run    = 1'b0;
        saw_block = 1'b0;
    endtask

    task automatic drive();
        in_valid = in_run && (src_idx < src_n);
        if (in_valid)
            in_data = {coef[4*src_idx+3], coef[4*src_idx+2],
                       coef[4*src_idx+1], coef[4*src_idx]};
        else
            in_data = '0;
        out_ready = !((cyc >= stall_lo) && (cyc < stall_hi));
    endtask

    task automatic accept();
        int w_old, w_new;
        w_old = (80 * src_idx) / 32;
        src_idx++;
        w_new = (80 * src_idx) / 32;
        for (int a = w_old; a < w_new; a++)
            sb.push_back('{addr: 11'(a), data: exp_word(a)});
        mfill += 80;
        if (src_idx == TOTAL_BEATS) in_run = 1'b0;
    endtask

    task automatic mon_word();
        sb_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL extra_word: got addr %0d data %h, expected no word", out_addr, out_data);
        end else begin
            e = sb.pop_front();
            chk("out_addr", 64'(out_addr), 64'(e.addr));
            chk("out_data", 64'(out_data), 64'(e.data));
        end
        cap.push_back(out_data);
        last_fire = cyc;
        nwords++;
        mfill -= 32;
    endtask

    task automatic cycle();
        @(negedge clk);
        chk("in_ready", 64'(in_ready), 64'(in_run && (mfill <= 48)));
        chk("out_valid", 64'(out_valid), 64'(mfill >= 32));
        if (in_run && !in_ready && !out_ready) saw_block = 1'b1;
        if (done) begin
            n_done++;
            done_cyc = cyc;
            chk("done_latency", 64'(cyc - last_fire), 64'd1);
        end
        if (cyc == done_cyc + 1) chk("busy_after_done", 64'(busy), 64'd0);
        if (out_valid && out_ready) mon_word();
        if (in_valid && in_ready) accept();
        cyc++;
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic start_sig(input int n);
        model_reset();
        src_n = n;
        start = 1'b1;
        cycle();
        start = 1'b0;
        in_run = 1'b1;
        drive();
    endtask

    task automatic run_to_done(input int budget);
        int t0;
        t0 = cyc;
        while (n_done == 0 && (cyc - t0) < budget) cycle();
        chk("done_seen", 64'(n_done > 0), 64'd1);
        repeat (3) cycle();
        chk("done_count", 64'(n_done), 64'd1);
        chk("word_count", 64'(nwords), 64'(TOTAL_WORDS));
        chk("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_zeroize();
        zeroize = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        zeroize = 1'b0;
        cyc++;
        model_reset();
        drive();
        @(negedge clk);
        chk("zero_busy", 64'(busy), 64'd0);
        chk("zero_out_valid", 64'(out_valid), 64'd0);
        chk("zero_in_ready", 64'(in_ready), 64'd0);
        chk("zero_done", 64'(done), 64'd0);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_data"}, 64'(out_data), 64'd0);
        chk({tag, "_out_addr"}, 64'(out_addr), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'd0);
    endtask

    initial begin
        int t0;

        tbl[0] = '{beat: {20'h4, 20'h3, 20'h2, 20'h1},
                   words: {32'h0, 32'h0, 32'h0, 32'h40000300, 32'h00200001}};
        tbl[1] = '{beat: {20'h0, 20'h0, 20'h0, 20'hFFFFF},
                   words: {32'h0, 32'h0, 32'h0, 32'h0, 32'h000FFFFF}};
        tbl[2] = '{beat: {20'h0, 20'h0, 20'hFFFFF, 20'h0},
                   words: {32'h0, 32'h0, 32'h0, 32'h000000FF, 32'hFFF00000}};
        tbl[3] = '{beat: {20'h0, 20'hFFFFF, 20'h0, 20'h0},
                   words: {32'h0, 32'h0, 32'h0, 32'h0FFFFF00, 32'h0}};
        tbl[4] = '{beat: {20'hFFFFF, 20'h0, 20'h0, 20'h0},
                   words: {32'h0, 32'h0, 32'h0000FFFF, 32'hF0000000, 32'h0}};
        tbl[5] = '{beat: {20'h55555, 20'h0F0F0, 20'hABCDE, 20'h12345},
                   words: {32'h0, 32'h0, 32'h00005555, 32'h50F0F0AB, 32'hCDE12345}};

        reset_n   = 1'b0;
        zeroize   = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        src_n     = 0;
        model_reset();
        #1;
        check_all_zero("rst");
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Asynchronous reset in the middle of a signature.
        for (int i = 0; i < 1792; i++) coef[i] = 20'($urandom);
        start_sig(TOTAL_BEATS);
        repeat (150) cycle();
        reset_n = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_busy", 64'(busy), 64'd0);
        chk("rel_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        drive();

        // Bit-ordering vectors: one data beat then one zero beat, five words.
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 8; k++)
                coef[k] = (k < 4) ? tbl[i].beat[20*k +: 20] : 20'h0;
            start_sig(2);
            t0 = cyc;
            while (nwords < 5 && (cyc - t0) < 50) cycle();
            for (int w = 0; w < 5; w++) begin
                if (w < cap.size())
                    chk($sformatf("tbl%0d_w%0d", i, w), 64'(cap[w]), 64'(tbl[i].words[32*w +: 32]));
                else
                    chk($sformatf("tbl%0d_w%0d", i, w), 64'hDEAD_0000_0000, 64'(tbl[i].words[32*w +: 32]));
            end
            do_zeroize();
        end

        // Full signature of all-ones coefficients, sink always ready.
        for (int i = 0; i < 1792; i++) coef[i] = 20'hFFFFF;
        start_sig(TOTAL_BEATS);
        run_to_done(1300);
        chk("full_last_word", 64'(cap[TOTAL_WORDS-1]), 64'hFFFF_FFFF);

        // Ten-cycle sink stall in the middle of a random signature.
        for (int i = 0; i < 1792; i++) coef[i] = 20'($urandom);
        stall_lo = cyc + 100;
        stall_hi = stall_lo + 10;
        start_sig(TOTAL_BEATS);
        run_to_done(1400);
        chk("bp_in_ready_dropped", 64'(saw_block), 64'd1);
        stall_lo = -1;
        stall_hi = -1;

        // Zeroize at word 500, then a fresh signature restarts at addr 0.
        for (int i = 0; i < 1792; i++) coef[i] = 20'($urandom);
        start_sig(TOTAL_BEATS);
        t0 = cyc;
        while (nwords < 500 && (cyc - t0) < 700) cycle();
        chk("zw_reached_500", 64'(nwords), 64'd500);
        do_zeroize();
        for (int i = 0; i < 1792; i++) coef[i] = 20'($urandom);
        start_sig(TOTAL_BEATS);
        run_to_done(1300);

`ifdef SIG_Z_PACK_PROTO_CHK_EN
        for (int i = 0; i < 1792; i++) coef[i] = 20'($urandom);
        start_sig(TOTAL_BEATS);
        repeat (100) cycle();
        chk("chk_error_clean", 64'(error), 64'd0);
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        chk("chk_error_set", 64'(error), 64'd1);
        run_to_done(1300);
        chk("chk_error_held", 64'(error), 64'd1);
        do_zeroize();
        chk("chk_error_cleared", 64'(error), 64'd0);
`else
        chk("error_tied_low", 64'(error), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
